// File: rtl/inst_fetch_pc_unit.sv
// ----------------------------------------------------------------------------
// inst_fetch_pc_unit
//   Owns the program counter and the instruction-fetch path that feeds decode.
//   A fetch request drives the IM address, waits MEM_LAT cycles, latches the
//   instruction word and then pulses o_inst_valid. The decoded fields and the
//   sign-extended immediate are taken from the latched word. A PC-update pulse
//   commits pc+4 or pc+imm, or halts the unit when the target is illegal.
//
// Ports
//   i_clk, i_rst        clock (rising edge), asynchronous active-high reset
//   i_fetch_req         1-cycle pulse, fetch at current PC (ignored when busy/halted)
//   i_pc_update         1-cycle pulse, commit next PC (honoured in IDLE only)
//   i_branch_flag       qualifies i_pc_update: 1 = pc+imm, 0 = pc+4
//   i_im_rdata          IM read data
//   o_im_addr, o_im_ren IM byte address (= PC) and read strobe
//   o_inst_valid        1-cycle pulse once decoded outputs are updated
//   o_busy              fetch in progress
//   o_pc                current PC
//   o_opcode .. o_rd    raw instruction fields
//   o_imm               sign-extended immediate (I/S/B formats, else 0)
//   o_invalid_pc        combinational, next-PC target is illegal
//   o_halted            sticky, set after an illegal PC update
// ----------------------------------------------------------------------------
// state  | meaning
// S_IDLE | waiting for a fetch request or a PC update
// S_WAIT | IM read outstanding, counting memory latency
// S_DONE | instruction latched, o_inst_valid asserted on exit
// S_HALT | illegal PC update seen, absorbing until reset
// ----------------------------------------------------------------------------
module inst_fetch_pc_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int IM_BYTES   = 4096,
   parameter int MEM_LAT    = 2,
   parameter int RESET_PC   = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_fetch_req,
   input  logic                  i_pc_update,
   input  logic                  i_branch_flag,
   input  logic [DATA_WIDTH-1:0] i_im_rdata,
   output logic [ADDR_WIDTH-1:0] o_im_addr,
   output logic                  o_im_ren,
   output logic                  o_inst_valid,
   output logic                  o_busy,
   output logic [ADDR_WIDTH-1:0] o_pc,
   output logic [6:0]            o_opcode,
   output logic [6:0]            o_func7,
   output logic [2:0]            o_func3,
   output logic [4:0]            o_rs1,
   output logic [4:0]            o_rs2,
   output logic [4:0]            o_rd,
   output logic [ADDR_WIDTH-1:0] o_imm,
   output logic                  o_invalid_pc,
   output logic                  o_halted
);

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(MEM_LAT - 1);
   localparam logic [ADDR_WIDTH-1:0] PC_LIMIT = ADDR_WIDTH'(IM_BYTES);
   localparam logic [ADDR_WIDTH-1:0] PC_RST   = ADDR_WIDTH'(RESET_PC);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2,
      S_HALT = 2'd3
   } state_t;

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic [ADDR_WIDTH-1:0]   pc;
   logic [DATA_WIDTH-1:0]   inst;
   logic [ADDR_WIDTH-1:0]   imm;
   logic [ADDR_WIDTH-1:0]   nxt_pc;
   logic                    nxt_bad;
   logic                    upd_take;

   // Field extraction always reads the latched word, so reset gives all zeros.
   assign o_opcode = inst[6:0];
   assign o_rd     = inst[11:7];
   assign o_func3  = inst[14:12];
   assign o_rs1    = inst[19:15];
   assign o_rs2    = inst[24:20];
   assign o_func7  = inst[31:25];

   always_comb begin
      imm = '0;
      case (inst[6:0])
         7'b0010011, 7'b0000011, 7'b0000111:
            imm = {{(ADDR_WIDTH-12){inst[31]}}, inst[31:20]};
         7'b0100011, 7'b0100111:
            imm = {{(ADDR_WIDTH-12){inst[31]}}, inst[31:25], inst[11:7]};
         7'b1100011:
            imm = {{(ADDR_WIDTH-13){inst[31]}}, inst[31], inst[7],
                   inst[30:25], inst[11:8], 1'b0};
         default:
            imm = '0;
      endcase
   end

   assign o_imm = imm;

   // Wrap-around add; an unsigned compare then catches negative wraps as out of range.
   assign nxt_pc       = i_branch_flag ? (pc + imm) : (pc + ADDR_WIDTH'(4));
   assign nxt_bad      = (nxt_pc >= PC_LIMIT) || (nxt_pc[1:0] != 2'b00);
   assign upd_take     = i_pc_update && (state == S_IDLE);
   assign o_invalid_pc = upd_take && nxt_bad;

   assign o_pc      = pc;
   assign o_im_addr = pc;
   assign o_busy    = (state == S_WAIT) || (state == S_DONE);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         pc           <= PC_RST;
         inst         <= '0;
         o_im_ren     <= 1'b0;
         o_inst_valid <= 1'b0;
         o_halted     <= 1'b0;
      end else begin
         o_im_ren     <= 1'b0;
         o_inst_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               // An update in the same cycle as a fetch request wins; the fetch is dropped.
               if (i_pc_update) begin
                  if (nxt_bad) begin
                     o_halted <= 1'b1;
                     state    <= S_HALT;
                  end else begin
                     pc <= nxt_pc;
                  end
               end else if (i_fetch_req) begin
                  cnt      <= '0;
                  o_im_ren <= 1'b1;
                  state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt == CNT_LAST) begin
                  inst  <= i_im_rdata;
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               o_inst_valid <= 1'b1;
               state        <= S_IDLE;
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch_pc_unit.sv
module tb_inst_fetch_pc_unit;

   localparam int MEM_LAT = 2;

   logic        i_clk;
   logic        i_rst;
   logic        i_fetch_req;
   logic        i_pc_update;
   logic        i_branch_flag;
   logic [31:0] i_im_rdata;
   logic [31:0] o_im_addr;
   logic        o_im_ren;
   logic        o_inst_valid;
   logic        o_busy;
   logic [31:0] o_pc;
   logic [6:0]  o_opcode;
   logic [6:0]  o_func7;
   logic [2:0]  o_func3;
   logic [4:0]  o_rs1;
   logic [4:0]  o_rs2;
   logic [4:0]  o_rd;
   logic [31:0] o_imm;
   logic        o_invalid_pc;
   logic        o_halted;

   inst_fetch_pc_unit #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .IM_BYTES(4096), .MEM_LAT(MEM_LAT), .RESET_PC(0)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_fetch_req(i_fetch_req), .i_pc_update(i_pc_update),
      .i_branch_flag(i_branch_flag), .i_im_rdata(i_im_rdata), .o_im_addr(o_im_addr),
      .o_im_ren(o_im_ren), .o_inst_valid(o_inst_valid), .o_busy(o_busy), .o_pc(o_pc),
      .o_opcode(o_opcode), .o_func7(o_func7), .o_func3(o_func3), .o_rs1(o_rs1),
      .o_rs2(o_rs2), .o_rd(o_rd), .o_imm(o_imm), .o_invalid_pc(o_invalid_pc),
      .o_halted(o_halted)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Instruction memory model: data follows the held address.
   logic [31:0] im [0:1023];
   assign i_im_rdata = im[o_im_addr[11:2]];

   int unsigned cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;
   int ren_cnt  = 0;

   typedef struct {
      logic [6:0]  opcode;
      logic [6:0]  func7;
      logic [2:0]  func3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      int unsigned cyc;
   } exp_t;

   exp_t exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every o_inst_valid pulse.
   always @(negedge i_clk) begin
      if (o_im_ren === 1'b1) ren_cnt++;
      if (o_inst_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_inst_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("valid_cycle", cyc, e.cyc);
            check("opcode", {25'd0, o_opcode}, {25'd0, e.opcode});
            check("func7",  {25'd0, o_func7},  {25'd0, e.func7});
            check("func3",  {29'd0, o_func3},  {29'd0, e.func3});
            check("rs1",    {27'd0, o_rs1},    {27'd0, e.rs1});
            check("rs2",    {27'd0, o_rs2},    {27'd0, e.rs2});
            check("rd",     {27'd0, o_rd},     {27'd0, e.rd});
            check("imm",    o_imm,             e.imm);
         end
      end
   end

   function automatic exp_t mk(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [31:0] imm);
      exp_t e;
      e.opcode = op; e.func7 = f7; e.func3 = f3;
      e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm; e.cyc = 0;
      return e;
   endfunction

   // Issue a fetch at the current PC; optionally push the expected decode.
   task automatic fetch(input exp_t e, input logic push, input logic [31:0] exp_addr);
      @(negedge i_clk);
      i_fetch_req = 1'b1;
      if (push) begin
         e.cyc = cyc + MEM_LAT + 2;
         exp_q.push_back(e);
      end
      @(negedge i_clk);
      i_fetch_req = 1'b0;
      check("im_ren_on_accept", {31'd0, o_im_ren}, 32'd1);
      check("busy_on_accept",   {31'd0, o_busy},   32'd1);
      check("im_addr",          o_im_addr,         exp_addr);
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 20) begin
         @(negedge i_clk);
         k++;
      end
      check("fetch_timeout", {31'd0, (exp_q.size() != 0)}, 32'd0);
      exp_q.delete();
      @(negedge i_clk);
   endtask

   task automatic pc_update(input logic br, input logic [31:0] exp_pc, input logic exp_inv);
      @(negedge i_clk);
      i_pc_update   = 1'b1;
      i_branch_flag = br;
      #1;
      check("invalid_pc", {31'd0, o_invalid_pc}, {31'd0, exp_inv});
      @(negedge i_clk);
      i_pc_update   = 1'b0;
      i_branch_flag = 1'b0;
      check("pc_after_update", o_pc, exp_pc);
      check("halted_after_update", {31'd0, o_halted}, {31'd0, exp_inv});
   endtask

   exp_t e_addi, e_sw, e_bneg, e_bfar;
   int   ren_snap;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) im[i] = 32'h0;
      im[0] = 32'h00500093;   // addi x1,x0,5
      im[1] = 32'hFE20AE23;   // sw x2,-4(x1)
      im[2] = 32'hFE000CE3;   // beq, imm -8
      im[3] = 32'h7E0008E3;   // beq, imm 4080

      e_addi = mk(7'h13, 7'h00, 3'd0, 5'd0, 5'd5, 5'd1,  32'd5);
      e_sw   = mk(7'h23, 7'h7F, 3'd2, 5'd1, 5'd2, 5'd28, 32'hFFFF_FFFC);
      e_bneg = mk(7'h63, 7'h7F, 3'd0, 5'd0, 5'd0, 5'd25, 32'hFFFF_FFF8);
      e_bfar = mk(7'h63, 7'h3F, 3'd0, 5'd0, 5'd0, 5'd17, 32'd4080);

      i_rst = 1'b1; i_fetch_req = 1'b0; i_pc_update = 1'b0; i_branch_flag = 1'b0;
      #1;
      check("rst_pc",      o_pc,                    32'd0);
      check("rst_busy",    {31'd0, o_busy},         32'd0);
      check("rst_halted",  {31'd0, o_halted},       32'd0);
      check("rst_ren",     {31'd0, o_im_ren},       32'd0);
      check("rst_valid",   {31'd0, o_inst_valid},   32'd0);
      check("rst_opcode",  {25'd0, o_opcode},       32'd0);
      check("rst_imm",     o_imm,                   32'd0);
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;

      // T1: addi at PC 0; an update during WAIT must be ignored.
      fetch(e_addi, 1'b1, 32'd0);
      i_pc_update = 1'b1;
      #1;
      check("invalid_pc_in_wait", {31'd0, o_invalid_pc}, 32'd0);
      @(negedge i_clk);
      i_pc_update = 1'b0;
      check("pc_held_in_wait", o_pc, 32'd0);
      wait_done();

      // T2: sequential update, then S-type at PC 4 and branch back.
      pc_update(1'b0, 32'd4, 1'b0);
      fetch(e_sw, 1'b1, 32'd4);
      wait_done();
      pc_update(1'b1, 32'd0, 1'b0);

      // T3: reach PC 8, negative branch back to 0.
      pc_update(1'b0, 32'd4, 1'b0);
      pc_update(1'b0, 32'd8, 1'b0);
      fetch(e_bneg, 1'b1, 32'd8);
      wait_done();
      pc_update(1'b1, 32'd0, 1'b0);

      // T5: re-pulsed request during WAIT is dropped.
      ren_snap = ren_cnt;
      fetch(e_addi, 1'b1, 32'd0);
      i_fetch_req = 1'b1;
      @(negedge i_clk);
      i_fetch_req = 1'b0;
      wait_done();
      repeat (4) @(negedge i_clk);
      check("single_ren_repulse", ren_cnt - ren_snap, 32'd1);

      // Simultaneous request and update in IDLE: update wins.
      ren_snap = ren_cnt;
      @(negedge i_clk);
      i_fetch_req = 1'b1; i_pc_update = 1'b1; i_branch_flag = 1'b0;
      #1;
      check("invalid_pc_simul", {31'd0, o_invalid_pc}, 32'd0);
      @(negedge i_clk);
      i_fetch_req = 1'b0; i_pc_update = 1'b0;
      check("pc_simul", o_pc, 32'd4);
      check("busy_simul", {31'd0, o_busy}, 32'd0);
      repeat (4) @(negedge i_clk);
      check("no_ren_simul", ren_cnt - ren_snap, 32'd0);

      // T6: reset during WAIT; no valid may follow.
      fetch(e_sw, 1'b0, 32'd4);
      #2;
      i_rst = 1'b1;
      #1;
      check("rst_mid_busy", {31'd0, o_busy}, 32'd0);
      check("rst_mid_pc",   o_pc,            32'd0);
      check("rst_mid_opcode", {25'd0, o_opcode}, 32'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      repeat (6) @(negedge i_clk);
      check("rst_mid_idle_pc", o_pc, 32'd0);

      // T4: climb to 4092 via a far branch, then step out of range.
      pc_update(1'b0, 32'd4,  1'b0);
      pc_update(1'b0, 32'd8,  1'b0);
      pc_update(1'b0, 32'd12, 1'b0);
      fetch(e_bfar, 1'b1, 32'd12);
      wait_done();
      pc_update(1'b1, 32'd4092, 1'b0);
      pc_update(1'b0, 32'd4092, 1'b1);
      ren_snap = ren_cnt;
      @(negedge i_clk);
      i_fetch_req = 1'b1;
      @(negedge i_clk);
      i_fetch_req = 1'b0;
      repeat (4) @(negedge i_clk);
      check("no_ren_halted", ren_cnt - ren_snap, 32'd0);
      check("busy_halted", {31'd0, o_busy}, 32'd0);
      i_pc_update = 1'b1;
      #1;
      check("invalid_pc_halted", {31'd0, o_invalid_pc}, 32'd0);
      @(negedge i_clk);
      i_pc_update = 1'b0;
      check("pc_halted", o_pc, 32'd4092);
      check("halted_sticky", {31'd0, o_halted}, 32'd1);

      // Misaligned target: pc 0 + imm 5.
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      check("halted_cleared", {31'd0, o_halted}, 32'd0);
      fetch(e_addi, 1'b1, 32'd0);
      wait_done();
      pc_update(1'b1, 32'd0, 1'b1);

      repeat (3) @(negedge i_clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
